id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the pipelined RISC-V core, sitting directly upstream of the ALU.
- Captures decoded operands and control, and resolves MEM→EX and WB→EX forwarding.
- Drives the ALU's opcode and srcA/srcB, plus store data and downstream control.
- Detects load-use hazards and inserts EX bubbles; handles stall and flush.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  global pipeline freeze (EX/MEM/WB hold)
- flush  in  1  kill instruction entering EX (taken branch/jump)
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  RA_W  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_opc  in  3  ALU opcode (ADD=000 … SLTU=110)
- id_src_a_pc  in  1  srcA = PC instead of rs1
- id_src_b_imm  in  1  srcB = imm instead of rs2
- id_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
- id_reg_write, id_mem_read, id_mem_write  in  1  control
- mem_rd  in  RA_W;  mem_reg_write  in  1;  mem_result  in  XLEN  EX/MEM forward source
- wb_rd  in  RA_W;  wb_reg_write  in  1;  wb_result  in  XLEN  MEM/WB forward source
- ex_valid  out  1
- ex_opc  out  3  to ALU opc
- ex_src_a, ex_src_b  out  XLEN  to ALU srcA/srcB
- ex_store_data  out  XLEN  forwarded rs2
- ex_pc  out  XLEN;  ex_rd  out  RA_W
- ex_reg_write, ex_mem_read, ex_mem_write  out  1
- load_use_stall  out  1  to PC/IF-ID hold logic

Behaviour:
- Reset (async, immediate):
  - All registered fields are 0: ex_valid=0, ex_opc=000 (ADD), reg_write/mem_read/mem_write=0, rd=0, data=0.
  - The combinational outputs therefore read ex_src_a=0, ex_src_b=0, load_use_stall=0.
- Register update priority at each posedge: flush > stall > load_use_stall > load.
  - flush: bubble (valid, reg_write, mem_read, mem_write ← 0; other fields ← 0).
  - stall: all registers hold.
  - load_use_stall (no flush/stall): bubble into EX; upstream holds ID.
  - Otherwise: capture all id_* fields. Raw rs data and indices are stored; forwarding is applied on the output side.
  - Capture is gated by id_valid: when id_valid=0, control bits are stored as 0.
- Forwarding (combinational, from registered rs1/rs2), per operand:
  - If mem_reg_write, mem_rd≠0 and mem_rd==rs, take mem_result.
  - Else if wb_reg_write, wb_rd≠0 and wb_rd==rs, take wb_result.
  - Else take the stored register data.
  - MEM has priority over WB when both match. x0 is never forwarded.
- Operand muxes:
  - ex_src_a = src_a_pc ? pc : fwd_rs1.
  - ex_src_b = src_b_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd≠0) & id_valid & ((id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Purely combinational.
  - Forced 0 while flush=1.
- Latency: one cycle ID→EX. Forwarded operands are valid in the same cycle the source result is presented.
- Reset mid-stall or mid-bubble: state is cleared immediately; the first post-reset edge loads normally.
- Width rules: no arithmetic here; all operands pass through unmodified at XLEN.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLTU 110), reused by the ALU and decoder.
  - XLEN and RA_W.
- One natural sub-module: forward_mux. It takes the rs index, the stored data and both forward sources, and returns the selected value. It is instantiated twice.

Test Plan:
- Reset, then load id_opc=001, rs1_data=10, rs2_data=3, no forward matches → next cycle ex_opc=001, ex_src_a=10, ex_src_b=3, ex_valid=1.
- EX rs1=x5 with mem_rd=5/mem_result=0x77 and wb_rd=5/wb_result=0x11, both reg_write → ex_src_a=0x77. Drop the mem match → 0x11. Set rd=0 on both → stored data.
- EX holds lw x6; ID has add using rs2=x6 with id_uses_rs2=1 → load_use_stall=1; next edge ex_valid=0, ex_mem_read=0. With id_uses_rs2=0 → no stall.
- stall=1 for 3 cycles while id_* changes → all ex_* outputs constant. Release → captures the current id_*.
- flush=1 with stall=1 and a load-use condition present → bubble inserted, load_use_stall=0.
- Assert rst asynchronously mid-cycle while ex_valid=1, ex_reg_write=1 → both drop to 0 before the next clock edge; ex_opc=000.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage_pkg
// Description : Shared constants for the ID/EX operand stage. Holds the
//               datapath and register-index widths, plus the ALU opcode
//               encodings that the decoder and the ALU also use.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_operand_stage_pkg;

  localparam int c_xlen = 32;
  localparam int c_ra_w = 5;

  localparam logic [2:0] c_alu_add  = 3'b000;
  localparam logic [2:0] c_alu_sub  = 3'b001;
  localparam logic [2:0] c_alu_and  = 3'b010;
  localparam logic [2:0] c_alu_or   = 3'b011;
  localparam logic [2:0] c_alu_xor  = 3'b100;
  localparam logic [2:0] c_alu_slt  = 3'b101;
  localparam logic [2:0] c_alu_sltu = 3'b110;

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_forward_mux.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage_forward_mux
// Description : Selects the freshest value of one source register. The
//               EX/MEM result wins over the MEM/WB result; x0 never forwards.
// Ports       : rs           - source register index held in EX
//               rs_data      - register-file data captured with rs
//               mem_*        - EX/MEM destination, write enable, result
//               wb_*         - MEM/WB destination, write enable, result
//               fwd_data     - selected operand value
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage_forward_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN = c_xlen,
  parameter int RA_W = c_ra_w
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
  assign w_wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs);

  always_comb begin
    fwd_data = rs_data;
    if (w_mem_hit) begin
      fwd_data = mem_result;
    end else if (w_wb_hit) begin
      fwd_data = wb_result;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX pipeline register in front of the ALU. Stores raw
//               decoded operands and control, applies MEM/WB forwarding on
//               the output side, muxes ALU srcA/srcB, and detects load-use
//               hazards (bubble into EX, ID held upstream).
// Ports       : clk, rst (async, active high)
//               stall, flush        - pipeline freeze / kill entering EX
//               id_*                - decoded instruction from ID
//               mem_*, wb_*         - forwarding sources
//               ex_*                - registered instruction toward the ALU
//               load_use_stall      - hold request to PC / IF-ID
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN = c_xlen,
  parameter int RA_W = c_ra_w
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [2:0]      id_opc,
  input  logic            id_src_a_pc,
  input  logic            id_src_b_imm,
  input  logic            id_uses_rs2,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [2:0]      ex_opc,
  output logic [XLEN-1:0] ex_src_a,
  output logic [XLEN-1:0] ex_src_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            load_use_stall
);

  typedef struct packed {
    logic            valid;
    logic [2:0]      opc;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_reg_t;

  // A bubble is an all-zero entry carrying the ADD opcode.
  localparam ex_reg_t c_bubble = '{opc: c_alu_add, default: '0};

  ex_reg_t         r_ex;
  ex_reg_t         w_capture;
  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic            w_load_use;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // Control bits are qualified by id_valid so an empty ID slot never
  // writes; data fields are captured as-is.
  always_comb begin
    w_capture           = c_bubble;
    w_capture.valid     = id_valid;
    w_capture.opc       = id_opc;
    w_capture.pc        = id_pc;
    w_capture.rs1       = id_rs1;
    w_capture.rs2       = id_rs2;
    w_capture.rd        = id_rd;
    w_capture.rs1_data  = id_rs1_data;
    w_capture.rs2_data  = id_rs2_data;
    w_capture.imm       = id_imm;
    w_capture.src_a_pc  = id_src_a_pc;
    w_capture.src_b_imm = id_src_b_imm;
    w_capture.reg_write = id_reg_write & id_valid;
    w_capture.mem_read  = id_mem_read  & id_valid;
    w_capture.mem_write = id_mem_write & id_valid;
  end

  // A load in EX cannot forward its data until MEM, so a dependent
  // instruction in ID must wait one cycle. A flush kills ID anyway.
  assign w_rs1_hit  = (id_rs1 == r_ex.rd);
  assign w_rs2_hit  = id_uses_rs2 && (id_rs2 == r_ex.rd);
  assign w_load_use = !flush && r_ex.valid && r_ex.mem_read && (r_ex.rd != '0)
                      && id_valid && (w_rs1_hit || w_rs2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= c_bubble;
    end else if (flush) begin
      r_ex <= c_bubble;
    end else if (stall) begin
      r_ex <= r_ex;
    end else if (w_load_use) begin
      r_ex <= c_bubble;
    end else begin
      r_ex <= w_capture;
    end
  end

  id_ex_operand_stage_forward_mux #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_fwd_rs1 (
    .rs            (r_ex.rs1),
    .rs_data       (r_ex.rs1_data),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (w_fwd_rs1)
  );

  id_ex_operand_stage_forward_mux #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_fwd_rs2 (
    .rs            (r_ex.rs2),
    .rs_data       (r_ex.rs2_data),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (w_fwd_rs2)
  );

  assign ex_valid       = r_ex.valid;
  assign ex_opc         = r_ex.opc;
  assign ex_src_a       = r_ex.src_a_pc  ? r_ex.pc  : w_fwd_rs1;
  assign ex_src_b       = r_ex.src_b_imm ? r_ex.imm : w_fwd_rs2;
  assign ex_store_data  = w_fwd_rs2;
  assign ex_pc          = r_ex.pc;
  assign ex_rd          = r_ex.rd;
  assign ex_reg_write   = r_ex.reg_write;
  assign ex_mem_read    = r_ex.mem_read;
  assign ex_mem_write   = r_ex.mem_write;
  assign load_use_stall = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_id_ex_operand_stage
// Description : Self-checking bench for id_ex_operand_stage with a
//               behavioural reference model of the EX slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int VW   = 1 + 3 + 4*XLEN + RA_W + 4;

  logic            clk = 1'b0;
  logic            rst, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]      id_opc;
  logic            id_src_a_pc, id_src_b_imm, id_uses_rs2;
  logic            id_reg_write, id_mem_read, id_mem_write;
  logic [RA_W-1:0] mem_rd, wb_rd;
  logic            mem_reg_write, wb_reg_write;
  logic [XLEN-1:0] mem_result, wb_result;
  logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [2:0]      ex_opc;
  logic [XLEN-1:0] ex_src_a, ex_src_b, ex_store_data, ex_pc;
  logic [RA_W-1:0] ex_rd;
  logic [VW-1:0]   dut_vec;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_opc(id_opc), .id_src_a_pc(id_src_a_pc),
    .id_src_b_imm(id_src_b_imm), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_result(mem_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_opc(ex_opc), .ex_src_a(ex_src_a),
    .ex_src_b(ex_src_b), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
  );

  assign dut_vec = {ex_valid, ex_opc, ex_src_a, ex_src_b, ex_store_data, ex_pc,
                    ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall};

  // ---------------- reference model: contents of the EX slot ----------------
  typedef struct {
    logic            valid;
    logic [2:0]      opc;
    logic [XLEN-1:0] pc, d1, d2, imm;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            a_pc, b_imm, rw, mr, mw;
  } model_t;

  model_t m;

  function automatic model_t empty_slot();
    model_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic logic [XLEN-1:0] ref_fwd(input logic [RA_W-1:0] rs,
                                              input logic [XLEN-1:0] d);
    if (rs == 0) return d;
    if (mem_reg_write && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd == rs) return wb_result;
    return d;
  endfunction

  function automatic logic ref_lus();
    if (flush || !m.valid || !m.mr || m.rd == 0 || !id_valid) return 1'b0;
    return (id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
  endfunction

  function automatic logic [VW-1:0] ref_vec();
    logic [XLEN-1:0] a, b, s;
    s = ref_fwd(m.rs2, m.d2);
    a = m.a_pc  ? m.pc  : ref_fwd(m.rs1, m.d1);
    b = m.b_imm ? m.imm : s;
    return {m.valid, m.opc, a, b, s, m.pc, m.rd, m.rw, m.mr, m.mw, ref_lus()};
  endfunction

  // Advance one clock edge and move the model the same way.
  task automatic edge_step();
    logic lus;
    @(posedge clk);
    lus = ref_lus();
    if (rst || flush) m = empty_slot();
    else if (stall) m = m;
    else if (lus) m = empty_slot();
    else begin
      m.valid = id_valid;     m.opc = id_opc;       m.pc = id_pc;
      m.rs1 = id_rs1;         m.rs2 = id_rs2;       m.rd = id_rd;
      m.d1 = id_rs1_data;     m.d2 = id_rs2_data;   m.imm = id_imm;
      m.a_pc = id_src_a_pc;   m.b_imm = id_src_b_imm;
      m.rw = id_valid & id_reg_write;
      m.mr = id_valid & id_mem_read;
      m.mw = id_valid & id_mem_write;
    end
    #1;
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
    id_rd = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_opc = '0;
    id_src_a_pc = 0; id_src_b_imm = 0; id_uses_rs2 = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0; mem_rd = '0; mem_reg_write = 0;
    mem_result = '0; wb_rd = '0; wb_reg_write = 0; wb_result = '0;
  endtask

  task automatic rand_id();
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc = $urandom; id_imm = $urandom;
    id_rs1 = RA_W'($urandom_range(0, 7)); id_rs2 = RA_W'($urandom_range(0, 7));
    id_rd = RA_W'($urandom_range(0, 7));
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_opc = 3'($urandom_range(0, 6));
    id_src_a_pc = 1'($urandom); id_src_b_imm = 1'($urandom);
    id_uses_rs2 = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
  endtask

  task automatic load_lw_x6();
    set_idle();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd6; id_rs1 = 5'd2;
    id_pc = 32'h100; #1;
    edge_step();
  endtask

  // ------------------------------- scenarios --------------------------------
  task automatic test_reset();
    set_idle();
    rst = 1;
    m = empty_slot();
    #12;
    vectors++;
    if (dut_vec !== ref_vec()) begin
      miscompares++;
      $display("FAIL reset_all: got %h expected %h", dut_vec, ref_vec());
    end
    vectors++;
    if (ex_opc !== c_alu_add || ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_opc_valid: got opc=%b valid=%b expected opc=000 valid=0",
               ex_opc, ex_valid);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    set_idle();
    id_valid = 1; id_opc = c_alu_sub; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_rs1_data = 32'd10; id_rs2_data = 32'd3; id_reg_write = 1; #1;
    edge_step();
    set_idle(); #1;
    vectors++;
    if (ex_opc !== 3'b001 || ex_src_a !== 32'd10 || ex_src_b !== 32'd3 || ex_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_load: got opc=%b a=%0d b=%0d v=%b expected opc=001 a=10 b=3 v=1",
               ex_opc, ex_src_a, ex_src_b, ex_valid);
    end
    vectors++;
    if (dut_vec !== ref_vec()) begin
      miscompares++;
      $display("FAIL basic_vec: got %h expected %h", dut_vec, ref_vec());
    end
  endtask

  task automatic test_forwarding();
    set_idle();
    id_valid = 1; id_rs1 = 5'd5; id_rs1_data = 32'h55; id_rs2 = 5'd7;
    id_rs2_data = 32'h99; #1;
    edge_step();
    set_idle();
    mem_rd = 5'd5; mem_result = 32'h77; mem_reg_write = 1;
    wb_rd = 5'd5; wb_result = 32'h11; wb_reg_write = 1; #1;
    vectors++;
    if (ex_src_a !== 32'h77) begin
      miscompares++;
      $display("FAIL fwd_mem_priority: got %h expected 00000077", ex_src_a);
    end
    mem_reg_write = 0; #1;
    vectors++;
    if (ex_src_a !== 32'h11) begin
      miscompares++;
      $display("FAIL fwd_wb: got %h expected 00000011", ex_src_a);
    end
    mem_reg_write = 1; mem_rd = 5'd0; wb_rd = 5'd0; #1;
    vectors++;
    if (ex_src_a !== 32'h55) begin
      miscompares++;
      $display("FAIL fwd_x0_none: got %h expected 00000055", ex_src_a);
    end
    wb_rd = 5'd7; #1;
    vectors++;
    if (ex_store_data !== 32'h11 || ex_src_b !== 32'h11) begin
      miscompares++;
      $display("FAIL fwd_rs2_wb: got store=%h b=%h expected 00000011", ex_store_data, ex_src_b);
    end
    vectors++;
    if (dut_vec !== ref_vec()) begin
      miscompares++;
      $display("FAIL fwd_vec: got %h expected %h", dut_vec, ref_vec());
    end
  endtask

  task automatic test_load_use();
    load_lw_x6();
    set_idle();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd6; id_uses_rs2 = 1; id_rd = 5'd7;
    id_reg_write = 1; #1;
    vectors++;
    if (load_use_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_detect: got %b expected 1", load_use_stall);
    end
    edge_step();
    vectors++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_bubble: got v=%b mr=%b expected v=0 mr=0", ex_valid, ex_mem_read);
    end
    edge_step();
    vectors++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
      miscompares++;
      $display("FAIL load_use_retry: got v=%b rd=%0d expected v=1 rd=7", ex_valid, ex_rd);
    end
    load_lw_x6();
    set_idle();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd6; id_uses_rs2 = 0; #1;
    vectors++;
    if (load_use_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_no_rs2: got %b expected 0", load_use_stall);
    end
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] held_pc, held_d1, new_pc;
    logic [2:0]      held_opc;
    set_idle();
    id_valid = 1; id_pc = $urandom; id_opc = c_alu_xor; id_rs1 = 5'd3;
    id_rs1_data = $urandom; id_rd = 5'd4; id_reg_write = 1; #1;
    held_pc = id_pc; held_d1 = id_rs1_data; held_opc = id_opc;
    edge_step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id(); #1;
      vectors++;
      if (ex_pc !== held_pc || ex_opc !== held_opc || ex_src_a !== held_d1) begin
        miscompares++;
        $display("FAIL stall_hold: got pc=%h opc=%b a=%h expected pc=%h opc=%b a=%h",
                 ex_pc, ex_opc, ex_src_a, held_pc, held_opc, held_d1);
      end
      edge_step();
    end
    stall = 0;
    rand_id(); id_valid = 1; #1;
    new_pc = id_pc;
    edge_step();
    vectors++;
    if (ex_pc !== new_pc || ex_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got pc=%h v=%b expected pc=%h v=1", ex_pc, ex_valid, new_pc);
    end
  endtask

  task automatic test_flush();
    load_lw_x6();
    set_idle();
    id_valid = 1; id_rs1 = 5'd6; id_reg_write = 1; stall = 1; flush = 1; #1;
    vectors++;
    if (load_use_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_lus_masked: got %b expected 0", load_use_stall);
    end
    edge_step();
    vectors++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_bubble: got v=%b mr=%b rw=%b expected all 0",
               ex_valid, ex_mem_read, ex_reg_write);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_async_reset();
    set_idle();
    id_valid = 1; id_opc = c_alu_slt; id_reg_write = 1; id_rd = 5'd9; #1;
    edge_step();
    vectors++;
    if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: got v=%b rw=%b expected v=1 rw=1", ex_valid, ex_reg_write);
    end
    #1 rst = 1;
    m = empty_slot();
    #1;
    vectors++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_opc !== 3'b000) begin
      miscompares++;
      $display("FAIL areset_mid_cycle: got v=%b rw=%b opc=%b expected 0 0 000",
               ex_valid, ex_reg_write, ex_opc);
    end
    @(negedge clk);
    rst = 0; #1;
    edge_step();
    vectors++;
    if (ex_valid !== 1'b1 || ex_opc !== c_alu_slt || ex_rd !== 5'd9) begin
      miscompares++;
      $display("FAIL areset_first_load: got v=%b opc=%b rd=%0d expected v=1 opc=101 rd=9",
               ex_valid, ex_opc, ex_rd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 7) == 0);
      mem_rd = RA_W'($urandom_range(0, 7)); mem_reg_write = 1'($urandom);
      mem_result = $urandom;
      wb_rd = RA_W'($urandom_range(0, 7)); wb_reg_write = 1'($urandom);
      wb_result = $urandom;
      #1;
      vectors++;
      if (dut_vec !== ref_vec()) begin
        miscompares++;
        $display("FAIL random_%0d: got %h expected %h", i, dut_vec, ref_vec());
      end
      edge_step();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_forwarding();
    test_load_use();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
